// File: rtl/instr_fetch_ctrl_if.sv
// Fetch controller bus: line-wide memory port plus the decode handshake.
interface instr_fetch_ctrl_if;

   logic [31:0]  MEM_ADDRESS;
   logic [127:0] MEM_LINE;
   logic         REDIRECT;
   logic [31:0]  REDIRECT_PC;
   logic         INSTR_VALID;
   logic         INSTR_READY;
   logic [31:0]  INSTR;
   logic [31:0]  INSTR_PC;

   // Controller side: drives the memory address and the instruction stream.
   modport master (
      output MEM_ADDRESS,
      input  MEM_LINE,
      input  REDIRECT,
      input  REDIRECT_PC,
      output INSTR_VALID,
      input  INSTR_READY,
      output INSTR,
      output INSTR_PC
   );

   // Front-end / memory side.
   modport slave (
      input  MEM_ADDRESS,
      output MEM_LINE,
      output REDIRECT,
      output REDIRECT_PC,
      input  INSTR_VALID,
      output INSTR_READY,
      input  INSTR,
      input  INSTR_PC
   );

endinterface

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: holds a line address for the fixed memory
// latency, buffers the returned 128-bit line and hands out one 32-bit word per
// decode handshake. Redirects abort any in-flight line and restart at the new PC.
module instr_fetch_ctrl #(
   parameter int unsigned MEM_LATENCY = 6,
   parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               rst,
   instr_fetch_ctrl_if.master bus
);

   localparam int unsigned CNT_W  = 8;
   localparam int unsigned PC_W   = 32;
   localparam int unsigned LINE_W = 128;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

   typedef enum logic {
      ST_WAIT  = 1'b0,
      ST_DRAIN = 1'b1
   } state_e;

   state_e              state_q;
   logic [PC_W-1:0]     fetch_pc_q;
   logic [CNT_W-1:0]    wait_cnt_q;
   logic [LINE_W-1:0]   line_buf_q;

   logic [PC_W-1:0]     fetch_pc_inc_d;
   logic [PC_W-1:0]     redirect_pc_d;
   logic [PC_W-1:0]     instr_c;
   logic                unused_redirect_lsb;

   // Sequential PC step; word index 3 rolls naturally into the next line base.
   assign fetch_pc_inc_d = fetch_pc_q + PC_W'(4);
   // Redirect target is word aligned; the low two bits are discarded.
   assign redirect_pc_d       = {bus.REDIRECT_PC[31:2], 2'b00};
   assign unused_redirect_lsb = ^bus.REDIRECT_PC[1:0];

   // Fetch FSM: reset > redirect > WAIT capture / DRAIN advance.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_q <= RESET_PC;
         state_q    <= ST_WAIT;
         wait_cnt_q <= '0;
         line_buf_q <= '0;
      end else if (bus.REDIRECT) begin
         fetch_pc_q <= redirect_pc_d;
         state_q    <= ST_WAIT;
         wait_cnt_q <= '0;
      end else begin
         case (state_q)
            ST_WAIT: begin
               if (wait_cnt_q == CNT_LAST) begin
                  line_buf_q <= bus.MEM_LINE;
                  state_q    <= ST_DRAIN;
                  wait_cnt_q <= '0;
               end else begin
                  wait_cnt_q <= wait_cnt_q + CNT_W'(1);
               end
            end
            ST_DRAIN: begin
               if (bus.INSTR_READY) begin
                  fetch_pc_q <= fetch_pc_inc_d;
                  if (fetch_pc_q[3:2] == 2'd3) begin
                     state_q    <= ST_WAIT;
                     wait_cnt_q <= '0;
                  end
               end
            end
         endcase
      end
   end

   // Word select out of the buffered line; word 0 sits in the top 32 bits.
   always_comb begin
      instr_c = line_buf_q[127:96];
      case (fetch_pc_q[3:2])
         2'd0:    instr_c = line_buf_q[127:96];
         2'd1:    instr_c = line_buf_q[95:64];
         2'd2:    instr_c = line_buf_q[63:32];
         default: instr_c = line_buf_q[31:0];
      endcase
   end

   assign bus.MEM_ADDRESS = {fetch_pc_q[31:4], 4'b0000};
   assign bus.INSTR_VALID = (state_q == ST_DRAIN);
   assign bus.INSTR       = instr_c;
   assign bus.INSTR_PC    = fetch_pc_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: two instances (latency 6 and 1) share stimulus,
// each checked every cycle against a transaction-level reference model.
module tb_instr_fetch_ctrl;

   localparam int unsigned LAT_A  = 6;
   localparam int unsigned LAT_B  = 1;
   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        ready = 1'b0;

   int n_cmp = 0;
   int n_err = 0;

   instr_fetch_ctrl_if bus_a ();
   instr_fetch_ctrl_if bus_b ();

   // Memory contents: words 0..3 from the directed scenario, a bijective hash elsewhere.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [31:0] w;
      if (a[31:4] == 28'd0) begin
         case (a[3:2])
            2'd0:    w = 32'h0022_3820;
            2'd1:    w = 32'h0000_0001;
            2'd2:    w = 32'h0000_0002;
            default: w = 32'h0000_0003;
         endcase
      end else begin
         w = {a[15:0], a[31:16]} ^ 32'h5A5A_1234;
      end
      return w;
   endfunction

   function automatic logic [127:0] mem_line(input logic [31:0] a);
      return {mem_word(a), mem_word(a + 32'd4), mem_word(a + 32'd8), mem_word(a + 32'd12)};
   endfunction

   assign bus_a.REDIRECT    = redirect;
   assign bus_a.REDIRECT_PC = redirect_pc;
   assign bus_a.INSTR_READY = ready;
   assign bus_a.MEM_LINE    = mem_line(bus_a.MEM_ADDRESS);
   assign bus_b.REDIRECT    = redirect;
   assign bus_b.REDIRECT_PC = redirect_pc;
   assign bus_b.INSTR_READY = ready;
   assign bus_b.MEM_LINE    = mem_line(bus_b.MEM_ADDRESS);

   instr_fetch_ctrl #(.MEM_LATENCY(LAT_A), .RESET_PC(RST_PC)) u_dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a)
   );

   instr_fetch_ctrl #(.MEM_LATENCY(LAT_B), .RESET_PC(RST_PC)) u_dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Reference model: a line becomes visible LAT edges after its fetch starts.
   int          m_edge = 0;
   int          m_start [2];
   logic [31:0] m_pc    [2];
   bit          m_zero  [2];
   bit          m_live  = 1'b0;

   function automatic int lat_of(input int k);
      return (k == 0) ? int'(LAT_A) : int'(LAT_B);
   endfunction

   function automatic bit m_valid(input int k);
      return m_live && ((m_edge - m_start[k]) >= lat_of(k));
   endfunction

   always @(posedge clk) begin : ref_model
      bit v;
      for (int k = 0; k < 2; k++) begin
         v = m_valid(k);
         if (rst) begin
            m_pc[k]    = RST_PC;
            m_start[k] = m_edge + 1;
            m_zero[k]  = 1'b1;
         end else if (redirect) begin
            m_pc[k]    = {redirect_pc[31:2], 2'b00};
            m_start[k] = m_edge + 1;
         end else if (v && ready) begin
            if (m_pc[k][3:2] == 2'd3) m_start[k] = m_edge + 1;
            m_pc[k] = m_pc[k] + 32'd4;
         end
      end
      if (rst) m_live = 1'b1;
      m_edge++;
      for (int k = 0; k < 2; k++) begin
         if (m_valid(k)) m_zero[k] = 1'b0;
      end
   end

   task automatic check_model();
      logic [31:0] vv, pp, aa, ii;
      string       t;
      if (!m_live) return;
      for (int k = 0; k < 2; k++) begin
         if (k == 0) begin
            t = "a";
            vv = 32'(bus_a.INSTR_VALID); pp = bus_a.INSTR_PC; aa = bus_a.MEM_ADDRESS; ii = bus_a.INSTR;
         end else begin
            t = "b";
            vv = 32'(bus_b.INSTR_VALID); pp = bus_b.INSTR_PC; aa = bus_b.MEM_ADDRESS; ii = bus_b.INSTR;
         end
         check_eq($sformatf("model_valid_%s", t), vv, 32'(m_valid(k)));
         check_eq($sformatf("model_pc_%s", t), pp, m_pc[k]);
         check_eq($sformatf("model_addr_%s", t), aa, {m_pc[k][31:4], 4'b0000});
         if (m_valid(k))
            check_eq($sformatf("model_instr_%s", t), ii, mem_word(m_pc[k]));
         else if (m_zero[k])
            check_eq($sformatf("model_zero_%s", t), ii, 32'h0);
      end
   endtask

   // One clock: drive inputs, let the edge happen, check on the falling edge.
   task automatic cycle(input logic r, input logic rd, input logic [31:0] rp, input logic rdy);
      rst = r; redirect = rd; redirect_pc = rp; ready = rdy;
      @(posedge clk);
      @(negedge clk);
      check_model();
   endtask

   // Idle through one full latency on instance A; valid only on the last edge.
   task automatic drain_wait();
      for (int i = 1; i <= int'(LAT_A); i++) begin
         cycle(1'b0, 1'b0, 32'h0, 1'b0);
         check_eq("lat_valid", 32'(bus_a.INSTR_VALID), (i == int'(LAT_A)) ? 32'd1 : 32'd0);
      end
   endtask

   task automatic check_reset_state();
      check_eq("rst_valid_a", 32'(bus_a.INSTR_VALID), 32'd0);
      check_eq("rst_pc_a", bus_a.INSTR_PC, RST_PC);
      check_eq("rst_addr_a", bus_a.MEM_ADDRESS, 32'h0);
      check_eq("rst_instr_a", bus_a.INSTR, 32'h0);
      check_eq("rst_valid_b", 32'(bus_b.INSTR_VALID), 32'd0);
      check_eq("rst_pc_b", bus_b.INSTR_PC, RST_PC);
      check_eq("rst_addr_b", bus_b.MEM_ADDRESS, 32'h0);
      check_eq("rst_instr_b", bus_b.INSTR, 32'h0);
   endtask

   initial begin
      logic        r, rd, rdy;
      logic [31:0] rp;

      // Reset, then first line with decode always ready.
      cycle(1'b1, 1'b0, 32'h0, 1'b1);
      cycle(1'b1, 1'b0, 32'h0, 1'b1);
      check_reset_state();
      for (int i = 1; i < int'(LAT_A); i++) begin
         cycle(1'b0, 1'b0, 32'h0, 1'b1);
         check_eq("wait_addr", bus_a.MEM_ADDRESS, 32'h0);
         check_eq("wait_valid", 32'(bus_a.INSTR_VALID), 32'd0);
      end
      cycle(1'b0, 1'b0, 32'h0, 1'b1);
      check_eq("first_valid", 32'(bus_a.INSTR_VALID), 32'd1);
      check_eq("first_instr", bus_a.INSTR, 32'h0022_3820);
      check_eq("first_pc", bus_a.INSTR_PC, 32'h0);
      cycle(1'b0, 1'b0, 32'h0, 1'b1);
      check_eq("pc4", bus_a.INSTR_PC, 32'h4);

      // Backpressure at PC 4.
      for (int i = 0; i < 10; i++) begin
         cycle(1'b0, 1'b0, 32'h0, 1'b0);
         check_eq("bp_valid", 32'(bus_a.INSTR_VALID), 32'd1);
         check_eq("bp_pc", bus_a.INSTR_PC, 32'h4);
         check_eq("bp_instr", bus_a.INSTR, 32'h1);
      end
      cycle(1'b0, 1'b0, 32'h0, 1'b1);
      check_eq("rel_pc8", bus_a.INSTR_PC, 32'h8);
      check_eq("rel_instr2", bus_a.INSTR, 32'h2);
      cycle(1'b0, 1'b0, 32'h0, 1'b1);
      check_eq("rel_pcc", bus_a.INSTR_PC, 32'hC);
      check_eq("rel_instr3", bus_a.INSTR, 32'h3);
      cycle(1'b0, 1'b0, 32'h0, 1'b1);
      check_eq("line_end_valid", 32'(bus_a.INSTR_VALID), 32'd0);
      check_eq("line_end_addr", bus_a.MEM_ADDRESS, 32'h10);

      // Redirect mid-WAIT (count at 3) into word 1 of the same line.
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1);
      cycle(1'b0, 1'b1, 32'h0000_0017, 1'b1);
      check_eq("rdw_addr", bus_a.MEM_ADDRESS, 32'h10);
      check_eq("rdw_pc", bus_a.INSTR_PC, 32'h14);
      check_eq("rdw_valid", 32'(bus_a.INSTR_VALID), 32'd0);
      for (int i = 1; i < int'(LAT_A); i++) begin
         cycle(1'b0, 1'b0, 32'h0, 1'b0);
         check_eq("rdw_restart", 32'(bus_a.INSTR_VALID), 32'd0);
      end
      cycle(1'b0, 1'b0, 32'h0, 1'b0);
      check_eq("rdw_hit_valid", 32'(bus_a.INSTR_VALID), 32'd1);
      check_eq("rdw_hit_pc", bus_a.INSTR_PC, 32'h14);
      check_eq("rdw_hit_instr", bus_a.INSTR, mem_word(32'h14));
      cycle(1'b0, 1'b0, 32'h0, 1'b1);
      check_eq("rdw_pc18", bus_a.INSTR_PC, 32'h18);
      cycle(1'b0, 1'b0, 32'h0, 1'b1);
      check_eq("rdw_pc1c", bus_a.INSTR_PC, 32'h1C);
      cycle(1'b0, 1'b0, 32'h0, 1'b1);
      check_eq("rdw_next_addr", bus_a.MEM_ADDRESS, 32'h20);
      check_eq("rdw_next_valid", 32'(bus_a.INSTR_VALID), 32'd0);

      // Reset in the middle of a drain at PC 0x28.
      drain_wait();
      check_eq("l20_pc", bus_a.INSTR_PC, 32'h20);
      cycle(1'b0, 1'b0, 32'h0, 1'b1);
      cycle(1'b0, 1'b0, 32'h0, 1'b1);
      check_eq("l28_pc", bus_a.INSTR_PC, 32'h28);
      cycle(1'b1, 1'b0, 32'h0, 1'b1);
      check_reset_state();

      // Redirect together with a handshake at PC 8.
      drain_wait();
      cycle(1'b0, 1'b0, 32'h0, 1'b1);
      cycle(1'b0, 1'b0, 32'h0, 1'b1);
      check_eq("rh_pre_pc", bus_a.INSTR_PC, 32'h8);
      cycle(1'b0, 1'b1, 32'h0000_0040, 1'b1);
      check_eq("rh_pc", bus_a.INSTR_PC, 32'h40);
      check_eq("rh_valid", 32'(bus_a.INSTR_VALID), 32'd0);
      drain_wait();
      check_eq("rh_instr", bus_a.INSTR, mem_word(32'h40));

      // Address wrap from the last word of memory.
      cycle(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
      drain_wait();
      check_eq("wrap_pc", bus_a.INSTR_PC, 32'hFFFF_FFFC);
      check_eq("wrap_addr", bus_a.MEM_ADDRESS, 32'hFFFF_FFF0);
      check_eq("wrap_instr", bus_a.INSTR, mem_word(32'hFFFF_FFFC));
      cycle(1'b0, 1'b0, 32'h0, 1'b1);
      check_eq("wrap_next_addr", bus_a.MEM_ADDRESS, 32'h0);
      check_eq("wrap_next_pc", bus_a.INSTR_PC, 32'h0);
      check_eq("wrap_next_valid", 32'(bus_a.INSTR_VALID), 32'd0);
      drain_wait();
      check_eq("wrap_line0", bus_a.INSTR, 32'h0022_3820);

      // Random traffic against the model.
      for (int n = 0; n < 4000; n++) begin
         r   = ($urandom_range(0, 299) == 0);
         rd  = ($urandom_range(0, 15) == 0);
         rdy = ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 2))
            0:       rp = $urandom();
            1:       rp = {28'hFFF_FFFF, 4'($urandom())};
            default: rp = 32'($urandom_range(0, 255));
         endcase
         cycle(r, rd, rp, rdy);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
